sramc_drain_sequencer: RTL and testbench

Controller that sequences read-out of finished 16 × 16 int32 result tensors from the SAURIA SRAMC bank. Each tensor is 64 consecutive 128-bit lines holding 4 words per line, and matrix m starts at line m·64. The block issues line reads on a shared SRAMC read port, always yielding to the core, and buffers the returned lines in a small FIFO. It streams them out on a valid/ready interface tagged with matrix index and last-line marker, so the SoC side (DMA or checker) can drain results without software polling.

---
 rtl/sramc_drain_sequencer_if.sv | 44 ++++
 rtl/sramc_drain_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_sramc_drain_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sramc_drain_sequencer_if.sv
// SRAMC read port and result stream bundle for the drain sequencer.
// master = sequencer side, slave = SRAMC / SoC side.
interface sramc_drain_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int MAT_W  = 4
) ();

    logic              core_req_i;
    logic              sram_req_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_rdata_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [MAT_W-1:0]  out_mat_o;
    logic              out_last_o;

    modport master (
        input  core_req_i,
        input  sram_rdata_i,
        input  out_ready_i,
        output sram_req_o,
        output sram_addr_o,
        output out_valid_o,
        output out_data_o,
        output out_mat_o,
        output out_last_o
    );

    modport slave (
        output core_req_i,
        output sram_rdata_i,
        output out_ready_i,
        input  sram_req_o,
        input  sram_addr_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_mat_o,
        input  out_last_o
    );

endinterface

// File: rtl/sramc_drain_sequencer.sv
// Drains finished SAURIA result tensors from the SRAMC bank line by line
// and streams them out, tagged with matrix index and last-line marker.
module sramc_drain_sequencer #(
    parameter int DATA_W        = 128,
    parameter int ADDR_W        = 10,
    parameter int LINES_PER_MAT = 64,
    parameter int MAT_W         = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [MAT_W-1:0] base_mat_i,
    input  logic [MAT_W:0]   num_mats_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    sramc_drain_sequencer_if.master bus
);

    localparam int LINE_W = $clog2(LINES_PER_MAT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(LINES_PER_MAT - 1);
    localparam logic [MAT_W:0]    MAT_ONE  = (MAT_W + 1)'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [MAT_W-1:0]  base_q;
    logic [MAT_W:0]    num_q;
    logic [MAT_W:0]    mat_cnt_q;
    logic [LINE_W-1:0] line_cnt_q;

    logic              infl_q;
    logic [MAT_W-1:0]  infl_mat_q;
    logic              infl_last_q;

    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [MAT_W-1:0]      fifo_mat  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic             start_ok;
    logic             abort_act;
    logic             issue;
    logic             credit;
    logic             line_end;
    logic             mat_end;
    logic [MAT_W-1:0] mat_abs;
    logic             valid;
    logic             push;
    logic             pop;

    assign start_ok  = (state_q == IDLE) && start_i;
    assign abort_act = (state_q != IDLE) && abort_i;
    assign mat_abs   = base_q + mat_cnt_q[MAT_W-1:0];
    assign line_end  = (line_cnt_q == LINE_MAX);
    assign mat_end   = (mat_cnt_q == (num_q - MAT_ONE));

    // A line already requested but not yet landed still owns a FIFO slot.
    assign credit = (count_q + CNT_W'(infl_q)) < DEPTH_C;

    assign valid = (count_q != '0);
    assign pop   = valid && bus.out_ready_i;
    assign push  = infl_q && !abort_act;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // An empty drain passes through FLUSH so done_o lands
                // on the same cycle offset as the nothing-left check.
                if (start_i) begin
                    state_d = (num_mats_i == '0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (!bus.core_req_i && credit) begin
                    issue = 1'b1;
                    if (line_end && mat_end) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Finish as soon as the last beat is handed over.
                if (!infl_q &&
                    ((count_q == '0) ||
                     ((count_q == CNT_W'(1)) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_act) begin
            state_d = IDLE;
            issue   = 1'b0;
        end
    end

    // Drain parameters and line/matrix position counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q     <= '0;
            num_q      <= '0;
            mat_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else if (start_ok) begin
            base_q     <= base_mat_i;
            num_q      <= num_mats_i;
            mat_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else if (issue) begin
            line_cnt_q <= line_cnt_q + LINE_W'(1);
            if (line_end) begin
                mat_cnt_q <= mat_cnt_q + MAT_ONE;
            end
        end
    end

    // Tags of the single read in flight, applied when its data returns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            infl_q      <= 1'b0;
            infl_mat_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_mat_q  <= mat_abs;
                infl_last_q <= line_end;
            end
        end
    end

    // FIFO pointers and occupancy; an abort throws away buffered lines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort_act) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only observable while valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= bus.sram_rdata_i;
            fifo_mat[wr_ptr_q]  <= infl_mat_q;
            fifo_last[wr_ptr_q] <= infl_last_q;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE) && !abort_i;

    assign bus.sram_req_o  = issue;
    assign bus.sram_addr_o = ADDR_W'({mat_abs, line_cnt_q});

    assign bus.out_valid_o = valid;
    assign bus.out_data_o  = valid ? fifo_data[rd_ptr_q] : '0;
    assign bus.out_mat_o   = valid ? fifo_mat[rd_ptr_q] : '0;
    assign bus.out_last_o  = valid && fifo_last[rd_ptr_q];

endmodule

// File: tb/tb_sramc_drain_sequencer.sv
// Directed bench for sramc_drain_sequencer: drain timing, tags,
// core stalls, backpressure, abort, wrap and reset behaviour.
module tb_sramc_drain_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] base = '0;
    logic [4:0] num = '0;
    logic       busy;
    logic       done;

    sramc_drain_sequencer_if #(
        .DATA_W(128), .ADDR_W(10), .MAT_W(4)
    ) bus ();

    sramc_drain_sequencer #(
        .DATA_W(128), .ADDR_W(10), .LINES_PER_MAT(64),
        .MAT_W(4), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .base_mat_i(base),
        .num_mats_i(num),
        .abort_i(abort),
        .busy_o(busy),
        .done_o(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;

    logic [127:0] beat_data [$];
    logic [3:0]   beat_mat [$];
    logic         beat_last [$];
    int           beat_cyc [$];
    logic [9:0]   req_addr [$];
    int           req_cyc [$];
    int           done_cyc [$];
    int           busy_fall = -1;

    int           occ = 0;
    logic         hold_v = 1'b0;
    logic [127:0] hold_d;
    logic [3:0]   hold_m;
    logic         hold_l;
    logic         busy_prev = 1'b0;

    function automatic logic [127:0] line_data(input logic [9:0] a);
        return {4{22'd0, a}};
    endfunction

    // SRAMC model: every word of a line holds its line index.
    always @(posedge clk) begin
        if (bus.sram_req_o) bus.sram_rdata_i <= line_data(bus.sram_addr_o);
        else bus.sram_rdata_i <= '0;
    end

    // Monitor: records requests/beats and watches the port invariants.
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            hold_v = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== hold_d ||
                    bus.out_mat_o !== hold_m || bus.out_last_o !== hold_l) begin
                    failures++;
                    $display("FAIL hold_stable got v=%0b m=%0d l=%0b d=%h need v=1 m=%0d l=%0b d=%h",
                             bus.out_valid_o, bus.out_mat_o, bus.out_last_o,
                             bus.out_data_o, hold_m, hold_l, hold_d);
                end
            end
            if (bus.sram_req_o) begin
                checks++;
                if (bus.core_req_i) begin
                    failures++;
                    $display("FAIL core_yield got req=1 with core_req=1 need req=0");
                end
                checks++;
                if (occ >= 4) begin
                    failures++;
                    $display("FAIL credit got occupancy=%0d at request need <4", occ);
                end
                req_addr.push_back(bus.sram_addr_o);
                req_cyc.push_back(cyc - t0);
                occ++;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                beat_data.push_back(bus.out_data_o);
                beat_mat.push_back(bus.out_mat_o);
                beat_last.push_back(bus.out_last_o);
                beat_cyc.push_back(cyc - t0);
                occ--;
            end
            if (done) done_cyc.push_back(cyc - t0);
            if (busy_prev && !busy) busy_fall = cyc - t0;
            busy_prev = busy;
            hold_v = bus.out_valid_o && !bus.out_ready_i && !abort;
            hold_d = bus.out_data_o;
            hold_m = bus.out_mat_o;
            hold_l = bus.out_last_o;
            if (abort) occ = 0;
        end
    end

    task automatic clear_logs();
        beat_data.delete(); beat_mat.delete();
        beat_last.delete(); beat_cyc.delete();
        req_addr.delete(); req_cyc.delete();
        done_cyc.delete();
        busy_fall = -1;
    endtask

    task automatic do_start(input logic [3:0] b, input logic [4:0] n);
        clear_logs();
        @(posedge clk); #1;
        base = b; num = n; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base = ~b; num = 5'd16;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        int n = 0;
        while (done_cyc.size() == 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cyc.size() != 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, bus.sram_req_o, bus.out_valid_o, bus.out_last_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%0b done=%0b req=%0b valid=%0b last=%0b need all 0",
                     busy, done, bus.sram_req_o, bus.out_valid_o, bus.out_last_o);
        end
        checks++;
        if (bus.sram_addr_o !== 10'd0 || bus.out_mat_o !== 4'd0 || bus.out_data_o !== 128'd0) begin
            failures++;
            $display("FAIL reset_buses got addr=%0d mat=%0d data=%h need 0",
                     bus.sram_addr_o, bus.out_mat_o, bus.out_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.sram_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%0b req=%0b need 0", busy, bus.sram_req_o);
        end
    endtask

    task automatic test_one_matrix();
        bit ok;
        int bad = 0;
        do_start(4'd0, 5'd1);
        wait_done(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL one_done_timeout got none need done"); end
        checks++;
        if (req_addr.size() != 64) begin
            failures++; $display("FAIL one_req_count got %0d need 64", req_addr.size());
        end
        for (int i = 0; i < req_addr.size(); i++)
            if (req_addr[i] !== 10'(i) || req_cyc[i] != i + 1) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL one_addr_seq got %0d bad need 0", bad); end
        checks++;
        if (beat_data.size() != 64) begin
            failures++; $display("FAIL one_beat_count got %0d need 64", beat_data.size());
        end
        bad = 0;
        for (int i = 0; i < beat_data.size(); i++)
            if (beat_data[i] !== line_data(10'(i)) || beat_mat[i] !== 4'd0 ||
                beat_last[i] !== (i == 63)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL one_beats got %0d bad need 0", bad); end
        checks++;
        if (beat_cyc.size() != 64 || beat_cyc[0] != 3 || beat_cyc[63] != 66) begin
            failures++;
            $display("FAIL one_beat_timing got first=%0d last=%0d need 3 and 66",
                     beat_cyc.size() > 0 ? beat_cyc[0] : -1,
                     beat_cyc.size() > 0 ? beat_cyc[beat_cyc.size()-1] : -1);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 67) begin
            failures++;
            $display("FAIL one_done_cycle got %0d (n=%0d) need 67",
                     done_cyc.size() > 0 ? done_cyc[0] : -1, done_cyc.size());
        end
        checks++;
        if (busy_fall != 68) begin
            failures++; $display("FAIL one_busy_fall got %0d need 68", busy_fall);
        end
    endtask

    task automatic test_base3();
        bit ok;
        int bad = 0;
        int lasts = 0;
        do_start(4'd3, 5'd2);
        wait_done(300, ok);
        checks++;
        if (beat_data.size() != 128) begin
            failures++; $display("FAIL base3_count got %0d need 128", beat_data.size());
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            if (beat_data[i] !== line_data(10'(192 + i))) bad++;
            if (beat_mat[i] !== ((i < 64) ? 4'd3 : 4'd4)) bad++;
            if (beat_last[i]) begin
                lasts++;
                if (i != 63 && i != 127) bad++;
            end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL base3_beats got %0d bad need 0", bad); end
        checks++;
        if (lasts != 2) begin failures++; $display("FAIL base3_lasts got %0d need 2", lasts); end
        checks++;
        if (!ok || done_cyc[0] != 131) begin
            failures++;
            $display("FAIL base3_done got %0d need 131", ok ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int bad = 0;
        do_start(4'd0, 5'd8);
        while (done_cyc.size() == 0 && n < 5000) begin
            @(posedge clk); #1;
            bus.core_req_i = (n % 3 == 2);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            n++;
        end
        bus.core_req_i = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cyc.size() != 1) begin
            failures++; $display("FAIL stall_done got %0d pulses need 1", done_cyc.size());
        end
        checks++;
        if (req_addr.size() != 512 || beat_data.size() != 512) begin
            failures++;
            $display("FAIL stall_counts got req=%0d beats=%0d need 512",
                     req_addr.size(), beat_data.size());
        end
        for (int i = 0; i < beat_data.size(); i++)
            if (beat_data[i] !== line_data(10'(i)) || beat_mat[i] !== 4'(i / 64) ||
                beat_last[i] !== (i % 64 == 63)) bad++;
        for (int i = 0; i < req_addr.size(); i++)
            if (req_addr[i] !== 10'(i)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_order got %0d bad need 0", bad); end
    endtask

    task automatic test_ready_low();
        bit ok;
        int n = 0;
        int r10;
        int r20;
        int bad = 0;
        do_start(4'd0, 5'd1);
        while (beat_data.size() < 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 r10 = req_addr.size();
        repeat (10) @(posedge clk);
        #1 r20 = req_addr.size();
        checks++;
        if (r20 != r10) begin
            failures++; $display("FAIL rdylow_stop got %0d more reqs need 0", r20 - r10);
        end
        checks++;
        if (r20 - beat_data.size() != 4) begin
            failures++;
            $display("FAIL rdylow_outstanding got %0d need 4", r20 - beat_data.size());
        end
        bus.out_ready_i = 1'b1;
        wait_done(200, ok);
        for (int i = 0; i < beat_data.size(); i++)
            if (beat_data[i] !== line_data(10'(i)) || beat_last[i] !== (i == 63)) bad++;
        checks++;
        if (!ok || beat_data.size() != 64 || bad != 0) begin
            failures++;
            $display("FAIL rdylow_resume got beats=%0d bad=%0d done=%0b need 64/0/1",
                     beat_data.size(), bad, ok);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n = 0;
        int nb;
        int nr;
        int bad = 0;
        do_start(4'd0, 5'd1);
        while (beat_data.size() < 30 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got busy=%0b valid=%0b need 0 0", busy, bus.out_valid_o);
        end
        nb = beat_data.size();
        nr = req_addr.size();
        repeat (10) @(negedge clk);
        checks++;
        if (done_cyc.size() != 0 || beat_data.size() != nb || req_addr.size() != nr) begin
            failures++;
            $display("FAIL abort_quiet got done=%0d beats+=%0d reqs+=%0d need 0",
                     done_cyc.size(), beat_data.size() - nb, req_addr.size() - nr);
        end
        do_start(4'd0, 5'd1);
        wait_done(200, ok);
        for (int i = 0; i < beat_data.size(); i++)
            if (beat_data[i] !== line_data(10'(i))) bad++;
        for (int i = 0; i < req_addr.size(); i++)
            if (req_addr[i] !== 10'(i)) bad++;
        checks++;
        if (!ok || beat_data.size() != 64 || req_addr.size() != 64 || bad != 0) begin
            failures++;
            $display("FAIL abort_redrain got beats=%0d reqs=%0d bad=%0d need 64 64 0",
                     beat_data.size(), req_addr.size(), bad);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad = 0;
        logic [9:0] ea;
        do_start(4'd15, 5'd2);
        wait_done(300, ok);
        for (int i = 0; i < req_addr.size(); i++) begin
            ea = (i < 64) ? 10'(960 + i) : 10'(i - 64);
            if (req_addr[i] !== ea) bad++;
        end
        for (int i = 0; i < beat_data.size(); i++) begin
            ea = (i < 64) ? 10'(960 + i) : 10'(i - 64);
            if (beat_data[i] !== line_data(ea)) bad++;
            if (beat_mat[i] !== ((i < 64) ? 4'd15 : 4'd0)) bad++;
        end
        checks++;
        if (!ok || req_addr.size() != 128 || beat_data.size() != 128 || bad != 0) begin
            failures++;
            $display("FAIL wrap got reqs=%0d beats=%0d bad=%0d need 128 128 0",
                     req_addr.size(), beat_data.size(), bad);
        end
    endtask

    task automatic test_zero();
        do_start(4'd2, 5'd0);
        repeat (6) @(negedge clk);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 2) begin
            failures++;
            $display("FAIL zero_done got n=%0d cyc=%0d need 1 at 2",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
        checks++;
        if (req_addr.size() != 0 || beat_data.size() != 0) begin
            failures++;
            $display("FAIL zero_reads got reqs=%0d beats=%0d need 0",
                     req_addr.size(), beat_data.size());
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        int bad = 0;
        do_start(4'd0, 5'd1);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; base = 4'd5; num = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        repeat (5) @(negedge clk);
        for (int i = 0; i < req_addr.size(); i++)
            if (req_addr[i] !== 10'(i)) bad++;
        for (int i = 0; i < beat_mat.size(); i++)
            if (beat_mat[i] !== 4'd0) bad++;
        checks++;
        if (!ok || done_cyc.size() != 1 || done_cyc[0] != 67 ||
            req_addr.size() != 64 || bad != 0) begin
            failures++;
            $display("FAIL start_busy got done=%0d reqs=%0d bad=%0d need 1@67 64 0",
                     done_cyc.size(), req_addr.size(), bad);
        end
    endtask

    task automatic test_async_reset();
        do_start(4'd0, 5'd2);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bus.sram_req_o, bus.out_valid_o, bus.out_last_o} !== 5'b0) begin
            failures++;
            $display("FAIL arst_flags got busy=%0b done=%0b req=%0b valid=%0b last=%0b need 0",
                     busy, done, bus.sram_req_o, bus.out_valid_o, bus.out_last_o);
        end
        checks++;
        if (bus.sram_addr_o !== 10'd0 || bus.out_mat_o !== 4'd0 || bus.out_data_o !== 128'd0) begin
            failures++;
            $display("FAIL arst_buses got addr=%0d mat=%0d data=%h need 0",
                     bus.sram_addr_o, bus.out_mat_o, bus.out_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.sram_req_o !== 1'b0) begin
            failures++;
            $display("FAIL arst_stay_idle got busy=%0b req=%0b need 0", busy, bus.sram_req_o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.core_req_i = 1'b0;
        bus.out_ready_i = 1'b1;
        test_reset();
        test_one_matrix();
        test_base3();
        test_stall();
        test_ready_low();
        test_abort();
        test_wrap();
        test_zero();
        test_start_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
